// File: rtl/mem_stage_if.sv
//----------------------------------------------------------------------------
// exmem_if / memwb_if : pipeline register bundles around the MEM stage
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface exmem_if;
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } data_t;

  ctrl_t ctrl;
  data_t data;

  modport rd (input ctrl, input data);
  modport wr (output ctrl, output data);
endinterface

interface memwb_if;
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
  } data_t;

  ctrl_t ctrl;
  data_t data;

  modport rd (input ctrl, input data);
  modport wr (output ctrl, output data);
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
//----------------------------------------------------------------------------
// mem_stage : RV32I memory-access stage with req/gnt/rvalid data bus
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  exmem_if.rd         inputs,
  memwb_if.wr         outputs,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic        FaultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] TIMEOUT = 8'(BUS_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        stale_q, stale_d;

  logic [1:0]  w_a;
  logic [2:0]  w_f3;
  logic        w_is_store, w_is_load, w_mem_op;
  logic        w_illegal, w_misal, w_bad_op, w_legal_op;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_waiting, w_timeout;
  logic        w_req, w_stall, w_fault, w_capture, w_regwrite;
  logic        w_unused_imm;

  assign w_a        = inputs.data.ALUResult[1:0];
  assign w_f3       = inputs.ctrl.funct3;
  assign w_is_store = inputs.ctrl.MemWrite;
  assign w_is_load  = ~inputs.ctrl.MemWrite & (inputs.ctrl.ResultSrc == 2'b01);
  assign w_mem_op   = w_is_store | w_is_load;

  assign w_illegal  = w_is_store ? (w_f3 >= 3'b011)
                                 : ((w_f3 == 3'b011) || (w_f3[2:1] == 2'b11));
  assign w_misal    = ((w_f3[1:0] == 2'b01) && w_a[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_a != 2'b00));
  assign w_bad_op   = w_mem_op & (w_illegal | w_misal);
  assign w_legal_op = w_mem_op & ~w_bad_op;

  assign w_unused_imm = ^inputs.data.ImmExt;

  // Byte enables and lane replication are shared by loads and stores.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = inputs.data.WriteData;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{inputs.data.WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_a;
        w_wdata = {2{inputs.data.WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (w_a)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: ;
    endcase
    w_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (w_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = dmem_rdata;
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
  end

  assign w_waiting = (state_q == S_REQ) || (state_q == S_WAIT_R);
  assign w_timeout = w_waiting && (cnt_q == TIMEOUT);

  always_comb begin
    state_d   = state_q;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_legal_op) begin
          w_req = 1'b1;
          if (w_is_store) begin
            w_stall = ~dmem_gnt;
            state_d = dmem_gnt ? S_IDLE : S_REQ;
          end else begin
            w_stall = 1'b1;
            state_d = dmem_gnt ? S_WAIT_R : S_REQ;
          end
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          state_d = S_IDLE;
        end else begin
          w_req   = 1'b1;
          w_stall = ~(w_is_store & dmem_gnt);
          if (dmem_gnt) state_d = w_is_store ? S_IDLE : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (w_timeout) begin
          state_d = S_IDLE;
        end else begin
          w_stall = 1'b1;
          // A response owed to an earlier timed-out load is dropped here.
          if (dmem_rvalid && !stale_q) begin
            w_capture = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_fault = ((state_q == S_IDLE) && w_bad_op) || w_timeout;

  always_comb begin
    cnt_d = 8'd0;
    if ((state_d == state_q) && w_waiting) cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    stale_d = stale_q;
    if ((state_q == S_WAIT_R) && w_timeout) stale_d = 1'b1;
    else if (dmem_rvalid)                   stale_d = 1'b0;
  end

  assign rdata_d = w_capture ? w_ext : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      stale_q <= stale_d;
    end
  end

  // Bus handshake and stall drop the moment reset asserts, even mid-access.
  assign dmem_req   = w_req & rst_n;
  assign StallM     = w_stall & rst_n;
  assign FaultM     = w_fault & rst_n;
  assign dmem_we    = dmem_req & w_is_store;
  assign dmem_addr  = {inputs.data.ALUResult[31:2], 2'b00};
  assign dmem_be    = dmem_req ? w_be : 4'b0000;
  assign dmem_wdata = dmem_req ? w_wdata : 32'd0;

  assign w_regwrite = inputs.ctrl.RegWrite & ~w_stall & ~w_fault;

  assign outputs.ctrl.RegWrite  = w_regwrite;
  assign outputs.ctrl.ResultSrc = inputs.ctrl.ResultSrc;
  assign outputs.data.ALUResult = inputs.data.ALUResult;
  assign outputs.data.ReadData  = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign outputs.data.PCPlus4   = inputs.data.PCPlus4;
  assign outputs.data.Rd        = inputs.data.Rd;

  assign ALUResultM = inputs.data.ALUResult;
  assign RdM        = inputs.data.Rd;
  assign RegWriteM  = w_regwrite;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//----------------------------------------------------------------------------
// tb_mem_stage : vector table plus hand-written bus sequences for mem_stage
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alum;
  logic [4:0]  rdm;
  logic        rwm, stall, fault, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        gnt, rvalid;

  always #5 clk = ~clk;

  exmem_if ex ();
  memwb_if wb ();

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .inputs(ex), .outputs(wb),
    .ALUResultM(alum), .RdM(rdm), .RegWriteM(rwm), .StallM(stall), .FaultM(fault),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_be(be), .dmem_wdata(wdata),
    .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        g;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_fault;
    logic        e_rw;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  logic [31:0] ld_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                     input logic [31:0] alu, input logic [31:0] wd, input logic g,
                     input logic e_req, input logic e_we, input logic [3:0] e_be,
                     input logic [31:0] e_wdata, input logic e_stall, input logic e_fault,
                     input logic e_rw);
    vec_t v;
    v = '{rw, rs, mw, f3, alu, wd, g, e_req, e_we, e_be, e_wdata, e_stall, e_fault, e_rw};
    tbl.push_back(v);
  endtask

  task automatic drive_op(input logic rw, input logic [1:0] rs, input logic mw,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd);
    ex.ctrl.RegWrite   = rw;
    ex.ctrl.ResultSrc  = rs;
    ex.ctrl.MemWrite   = mw;
    ex.ctrl.funct3     = f3;
    ex.data.ALUResult  = alu;
    ex.data.WriteData  = wd;
    ex.data.PCPlus4    = 32'h0000_1004;
    ex.data.Rd         = 5'd7;
    ex.data.ImmExt     = 32'd0;
  endtask

  task automatic nop();
    drive_op(1'b0, 2'b00, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a load granted immediately, respond one cycle later, expect DONE next.
  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    int   stalls;
    bit   done;
    logic [31:0] e;
    stalls = 0;
    done   = 1'b0;
    cyc();
    drive_op(1'b1, 2'b01, 1'b0, f3, a, 32'd0);
    gnt = 1'b1;
    ld_q.push_back(exp);
    @(negedge clk);
    chk({nm, " req"}, {31'd0, req}, 32'd1);
    if (stall) stalls++;
    cyc();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = rd;
    @(negedge clk);
    if (stall) stalls++;
    for (int k = 0; k < 10 && !done; k++) begin
      cyc();
      rvalid = 1'b0;
      rdata  = 32'd0;
      @(negedge clk);
      if (!stall) done = 1'b1;
      else        stalls++;
    end
    if (!done) begin
      chk({nm, " completion"}, 32'd0, 32'd1);
      void'(ld_q.pop_front());
    end else begin
      e = ld_q.pop_front();
      chk({nm, " ReadData"}, wb.data.ReadData, e);
      chk({nm, " RegWrite"}, {31'd0, wb.ctrl.RegWrite}, 32'd1);
      chk({nm, " stall cycles"}, stalls, 32'd2);
    end
    cyc();
    nop();
  endtask

  initial begin
    vec_t v;
    int   stalls;
    int   k;
    rst_n  = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'd0;
    nop();

    //   rw rs     mw f3      alu          wd            g   req we be       wdata         st f  rw
    add(1, 2'b00, 0, 3'b000, 32'h1234,    32'hFFFF,     1,  0, 0, 4'b0000, 32'h0,        0, 0, 1);
    add(0, 2'b00, 1, 3'b010, 32'h100,     32'hDEADBEEF, 1,  1, 1, 4'b1111, 32'hDEADBEEF, 0, 0, 0);
    add(0, 2'b00, 1, 3'b000, 32'h101,     32'h12345678, 1,  1, 1, 4'b0010, 32'h78787878, 0, 0, 0);
    add(0, 2'b00, 1, 3'b001, 32'h102,     32'hCAFEBABE, 1,  1, 1, 4'b1100, 32'hBABEBABE, 0, 0, 0);
    add(0, 2'b00, 1, 3'b000, 32'h100,     32'h000000C3, 1,  1, 1, 4'b0001, 32'hC3C3C3C3, 0, 0, 0);
    add(0, 2'b00, 1, 3'b001, 32'h101,     32'h1,        1,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(0, 2'b00, 1, 3'b010, 32'h106,     32'h1,        1,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(0, 2'b00, 1, 3'b011, 32'h100,     32'h1,        1,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(1, 2'b01, 0, 3'b010, 32'h106,     32'h0,        0,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(1, 2'b01, 0, 3'b011, 32'h100,     32'h0,        0,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(1, 2'b01, 0, 3'b110, 32'h100,     32'h0,        0,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(1, 2'b01, 0, 3'b001, 32'h203,     32'h0,        0,  0, 0, 4'b0000, 32'h0,        0, 1, 0);
    add(1, 2'b10, 0, 3'b000, 32'h40,      32'h0,        0,  0, 0, 4'b0000, 32'h0,        0, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", {31'd0, req}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset ReadData", wb.data.ReadData, 32'd0);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc();
      drive_op(tbl[i].rw, tbl[i].rs, tbl[i].mw, tbl[i].f3, tbl[i].alu, tbl[i].wd);
      gnt = tbl[i].g;
      sb.push_back(tbl[i]);
      @(negedge clk);
      v = sb.pop_front();
      chk($sformatf("v%0d req", i), {31'd0, req}, {31'd0, v.e_req});
      chk($sformatf("v%0d we", i), {31'd0, we}, {31'd0, v.e_we});
      chk($sformatf("v%0d be", i), {28'd0, be}, {28'd0, v.e_be});
      chk($sformatf("v%0d wdata", i), wdata, v.e_wdata);
      chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, v.e_stall});
      chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, v.e_fault});
      chk($sformatf("v%0d RegWrite", i), {31'd0, wb.ctrl.RegWrite}, {31'd0, v.e_rw});
      chk($sformatf("v%0d ALUResultM", i), alum, v.alu);
      if (v.e_req) chk($sformatf("v%0d addr", i), addr, {v.alu[31:2], 2'b00});
    end
    cyc();
    nop();
    gnt = 1'b0;

    // SB with grant held off for three cycles: bus fields must not move.
    stalls = 0;
    cyc();
    drive_op(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000A5);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      gnt = (c == 3);
      @(negedge clk);
      chk($sformatf("sb c%0d req", c), {31'd0, req}, 32'd1);
      chk($sformatf("sb c%0d be", c), {28'd0, be}, 32'h8);
      chk($sformatf("sb c%0d wdata", c), wdata, 32'hA5A5A5A5);
      if (stall) stalls++;
    end
    chk("sb stall cycles", stalls, 32'd3);
    cyc();
    nop();
    gnt = 1'b0;
    @(negedge clk);
    chk("sb after req", {31'd0, req}, 32'd0);
    chk("sb after stall", {31'd0, stall}, 32'd0);

    do_load("lb", 3'b000, 32'h202, 32'h0080FF00, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h202, 32'h0080FF00, 32'h00000080);
    do_load("lh", 3'b001, 32'h202, 32'h80011234, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h002, 32'h80011234, 32'h00008001);
    do_load("lw", 3'b010, 32'h200, 32'h13579BDF, 32'h13579BDF);

    // LH granted, response never comes: abort after four wait cycles.
    cyc();
    drive_op(1'b1, 2'b01, 1'b0, 3'b001, 32'h200, 32'd0);
    gnt = 1'b1;
    @(negedge clk);
    chk("tmo issue stall", {31'd0, stall}, 32'd1);
    k = 1;
    while (k <= 10) begin
      cyc();
      gnt = 1'b0;
      @(negedge clk);
      if (fault) break;
      k++;
    end
    chk("tmo fault cycle", k, 32'd5);
    chk("tmo stall", {31'd0, stall}, 32'd0);
    chk("tmo RegWrite", {31'd0, wb.ctrl.RegWrite}, 32'd0);
    cyc();
    nop();
    rvalid = 1'b1;
    rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late rvalid stall", {31'd0, stall}, 32'd0);
    chk("late rvalid fault", {31'd0, fault}, 32'd0);
    chk("late rvalid ReadData", wb.data.ReadData, 32'd0);
    cyc();
    rvalid = 1'b0;
    rdata  = 32'd0;
    do_load("post-tmo lw", 3'b010, 32'h204, 32'h0BADF00D, 32'h0BADF00D);

    // Reset while WAIT_R: outputs drop without waiting for a clock edge.
    cyc();
    drive_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'd0);
    gnt = 1'b1;
    @(negedge clk);
    cyc();
    gnt = 1'b0;
    #1;
    chk("pre-rst stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst req", {31'd0, req}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    nop();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req", {31'd0, req}, 32'd0);
    do_load("post-rst lw", 3'b010, 32'h304, 32'h2468ACE0, 32'h2468ACE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline. It sits between the EX/MEM register (`exmem_if`) and the MEM/WB register (`memwb_if`). It drives a request/grant/response data-memory bus for loads and stores, and generates byte enables and store-data lane replication. It sign- or zero-extends load data, stalls the pipeline while an access is outstanding, and flags misaligned, illegal or timed-out accesses.

## Interface
- `BUS_TIMEOUT`, default 255: maximum wait cycles in REQ or WAIT_R before the access is aborted; 8-bit counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inputs`  `exmem_if.rd`  —  ctrl: RegWrite, ResultSrc[1:0] (00 ALU, 01 load, 10 PC+4), MemWrite, funct3[2:0]; data: ALUResult, WriteData, PCPlus4, Rd, ImmExt.
- `outputs`  `memwb_if.wr`  —  ctrl: RegWrite, ResultSrc; data: ALUResult, ReadData, PCPlus4, Rd.
- `ALUResultM`  out  32  forwarding value, equal to `inputs.data.ALUResult`.
- `RdM`  out  5  hazard unit.
- `RegWriteM`  out  1  hazard unit; equal to the gated `outputs.ctrl.RegWrite`.
- `StallM`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB.
- `FaultM`  out  1  one-cycle pulse on misaligned, illegal-funct3 or timeout.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address: `{ALUResult[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid; exactly one per granted load, at least 1 cycle after grant.
- `dmem_rdata`  in  32  load data.

## Operation
- Load: ResultSrc==01. Store: MemWrite==1. Otherwise the stage is pass-through with StallM=0.
- Byte offset is `a = ALUResult[1:0]`.
- Store byte enables:
  - SB: `0001<<a`
  - SH: `0011<<a`
  - SW: `1111`
- Store data: SB replicates `{4{WD[7:0]}}`, SH replicates `{2{WD[15:0]}}`, SW uses WD as is.
- Loads drive be as for stores of the same size.
- Load extraction: the byte or halfword is taken at offset `a`. LB/LH sign-extend, LBU/LHU zero-extend, LW is whole-word.
- Faults: no bus request is issued, FaultM pulses, and RegWrite is forced to 0.
  - Misaligned: halfword access with `a[0]=1`, or word access with `a!=0`.
  - Illegal funct3: load funct3 ∈ {011,110,111}; store funct3 ≥ 011.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE, legal memory op: dmem_req=1.
    - Store with gnt: completes, StallM=0, stay IDLE.
    - Store without gnt: → REQ.
    - Load with gnt: → WAIT_R.
    - Load without gnt: → REQ.
  - REQ: hold req and all bus fields stable until gnt. Store → IDLE on gnt; load → WAIT_R on gnt.
  - WAIT_R: on rvalid, capture extended data into `rdata_q` and go → DONE.
  - DONE: StallM=0, ReadData=`rdata_q`, no request; → IDLE unconditionally.
- StallM = legal memory op AND NOT (store-grant in IDLE/REQ, or state==DONE).
- Timeout: wait counter clears on entering REQ/WAIT_R and increments each cycle there. When it reaches BUS_TIMEOUT:
  - FaultM pulses, StallM drops that cycle, RegWrite is forced to 0;
  - state → IDLE;
  - a late rvalid is ignored.
- A fault or timeout never blocks the pipeline for more than 1 cycle beyond detection.
- Pass-through signals: ALUResult, PCPlus4, Rd, ResultSrc.
- While StallM=1, `outputs.ctrl.RegWrite`=0 (bubble).

## Timing
- Reset values: state IDLE, counter 0, `rdata_q`=0, dmem_req=0, StallM=0, FaultM=0.
- Asserting `rst_n` low mid-access aborts immediately; no request is re-issued after release until a new op arrives.
- Best-case latency:
  - Store: 0 stall cycles (gnt in the issue cycle).
  - Load: 2 stall cycles (issue+gnt, then rvalid, then DONE releases).
- Non-memory instructions: combinational through the stage, 0 stall.
- `outputs.data.ReadData` is valid only in DONE; otherwise 0.

## Test plan
- SW to 0x100, WD=0xDEADBEEF, gnt same cycle -> req=1, we=1, be=1111, wdata=0xDEADBEEF, StallM=0.
- SB to 0x103, WD=0x000000A5, gnt delayed 3 cycles -> be=1000, wdata=0xA5A5A5A5 held stable for 4 cycles, StallM=1 for 3 cycles.
- LB at 0x202, rdata=0x0080FF00, gnt immediate, rvalid 1 cycle later -> StallM=1 for 2 cycles, ReadData=0xFFFFFF80. Same stimulus with LBU -> 0x00000080.
- LW at 0x106 -> no req, FaultM=1 for one cycle, RegWrite out=0, StallM=0.
- LH at 0x200 with BUS_TIMEOUT=4 and rvalid never asserted -> FaultM after 4 cycles in WAIT_R, state IDLE, a later rvalid is ignored.
- `rst_n` low during WAIT_R -> req=0, StallM=0 asynchronously; after release the next LW completes normally.
